// File: rtl/icache_sa_fill.sv
// N-way set-associative instruction cache with integrated block miss-fill FSM.
// Latency: hits return data combinationally; a miss costs WORDS issue cycles + memory latency + 2 (DONE, retry).
// Backpressure: if_stall holds fetch on a miss or while a fill is in flight; memory is assumed always ready.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   if_req, if_addr           fetch request and byte address (bit 0 ignored)
//   if_data, if_hit, if_stall fetched word, combinational hit, fetch stall
//   flush                     invalidate all lines (deferred to IDLE if a fill is running)
//   mem_rd, mem_addr          one-word-per-cycle read request to memory
//   mem_rvalid, mem_rdata     in-order read responses
//   hit_cnt, miss_cnt         saturating event counters
module icache_sa_fill #(
  parameter int WAYS   = 2,
  parameter int SETS   = 64,
  parameter int WORDS  = 8,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [15:0]       if_data,
  output logic              if_hit,
  output logic              if_stall,
  input  logic              flush,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rvalid,
  input  logic [15:0]       mem_rdata,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt
);

  localparam int OFF_W  = $clog2(WORDS) + 1;
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
  localparam int WSEL_W = $clog2(WORDS);
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int AGE_W  = WAY_W;
  localparam int CNT_W  = WSEL_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

  // Storage: data and tags are never reset; valid and ages are.
  logic [15:0]                 r_data  [WAYS][SETS][WORDS];
  logic [TAG_W-1:0]            r_tag   [WAYS][SETS];
  logic [SETS-1:0]             r_valid [WAYS];
  logic [WAYS-1:0][AGE_W-1:0]  r_age   [SETS];

  state_t            r_state;
  logic              r_flush_pend;
  logic [15:0]       r_hit_cnt, r_miss_cnt;
  logic              r_mem_rd;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [CNT_W-1:0]  r_req_cnt, r_resp_cnt;
  logic [TAG_W-1:0]  r_fill_tag;
  logic [IDX_W-1:0]  r_fill_idx;
  logic [ADDR_W-1:0] r_fill_base;
  logic [WAY_W-1:0]  r_victim;

  logic [TAG_W-1:0]  w_tag;
  logic [IDX_W-1:0]  w_idx;
  logic [WSEL_W-1:0] w_wsel;
  logic [ADDR_W-1:0] w_base;
  logic              w_unused_lsb;
  logic              w_match, w_hit;
  logic [WAY_W-1:0]  w_hit_way, w_victim;
  logic [AGE_W-1:0]  w_max_age;

  assign w_tag        = if_addr[ADDR_W-1 -: TAG_W];
  assign w_idx        = if_addr[OFF_W +: IDX_W];
  assign w_wsel       = if_addr[1 +: WSEL_W];
  assign w_base       = {if_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign w_unused_lsb = if_addr[0];

  always_comb begin
    w_match   = 1'b0;
    w_hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[w][w_idx] && r_tag[w][w_idx] == w_tag) begin
        w_match   = 1'b1;
        w_hit_way = WAY_W'(w);
      end
    end
  end

  // A pending flush makes every line logically invalid until it is applied.
  assign w_hit    = if_req && (r_state == S_IDLE) && !r_flush_pend && w_match;
  assign if_hit   = w_hit;
  assign if_stall = (if_req && !w_hit) || (r_state != S_IDLE);
  assign if_data  = r_data[w_hit_way][w_idx][w_wsel];

  // Victim: lowest invalid way, else oldest way (lowest index on a tie).
  always_comb begin
    w_victim  = '0;
    w_max_age = r_age[w_idx][0];
    for (int w = 1; w < WAYS; w++) begin
      if (r_age[w_idx][w] > w_max_age) begin
        w_max_age = r_age[w_idx][w];
        w_victim  = WAY_W'(w);
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!r_valid[w][w_idx]) w_victim = WAY_W'(w);
    end
  end

  // Touched way becomes age 0. Ways at or below its old age step up by one
  // (saturating at WAYS-1): ages start all-zero, so including equal ages is
  // what spreads them into a distinct ordering as the set fills.
  function automatic logic [WAYS-1:0][AGE_W-1:0] lru_touch(
    input logic [WAYS-1:0][AGE_W-1:0] a,
    input logic [WAY_W-1:0]           way
  );
    lru_touch = a;
    for (int w = 0; w < WAYS; w++) begin
      if (WAY_W'(w) == way)
        lru_touch[w] = '0;
      else if (a[w] <= a[way] && a[w] != AGE_W'(WAYS - 1))
        lru_touch[w] = a[w] + 1'b1;
    end
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    sat_inc = (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_flush_pend <= 1'b0;
      r_hit_cnt    <= '0;
      r_miss_cnt   <= '0;
      r_mem_rd     <= 1'b0;
      r_mem_addr   <= '0;
      r_req_cnt    <= '0;
      r_resp_cnt   <= '0;
      r_fill_tag   <= '0;
      r_fill_idx   <= '0;
      r_fill_base  <= '0;
      r_victim     <= '0;
      for (int w = 0; w < WAYS; w++) r_valid[w] <= '0;
      for (int s = 0; s < SETS; s++) r_age[s] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_hit) begin
            r_hit_cnt    <= sat_inc(r_hit_cnt);
            r_age[w_idx] <= lru_touch(r_age[w_idx], w_hit_way);
          end
          // Flush beats a same-cycle miss; the request re-evaluates next cycle.
          if (flush || r_flush_pend) begin
            r_flush_pend <= 1'b0;
            for (int w = 0; w < WAYS; w++) r_valid[w] <= '0;
            for (int s = 0; s < SETS; s++) r_age[s] <= '0;
          end else if (if_req && !w_hit) begin
            r_fill_tag  <= w_tag;
            r_fill_idx  <= w_idx;
            r_fill_base <= w_base;
            r_victim    <= w_victim;
            r_miss_cnt  <= sat_inc(r_miss_cnt);
            r_mem_rd    <= 1'b1;
            r_mem_addr  <= w_base;
            r_req_cnt   <= CNT_W'(1);
            r_resp_cnt  <= '0;
            r_state     <= S_FILL;
          end
        end
        S_FILL: begin
          if (flush) r_flush_pend <= 1'b1;
          if (r_req_cnt == CNT_W'(WORDS)) begin
            r_mem_rd <= 1'b0;
          end else if (r_mem_rd) begin
            r_mem_addr <= r_fill_base + ADDR_W'({r_req_cnt, 1'b0});
            r_req_cnt  <= r_req_cnt + 1'b1;
          end
          if (mem_rvalid) begin
            r_resp_cnt <= r_resp_cnt + 1'b1;
            if (r_resp_cnt == CNT_W'(WORDS - 1)) r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (flush) r_flush_pend <= 1'b1;
          r_valid[r_victim][r_fill_idx] <= 1'b1;
          r_age[r_fill_idx]             <= lru_touch(r_age[r_fill_idx], r_victim);
          r_state                       <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && r_state == S_FILL && mem_rvalid)
      r_data[r_victim][r_fill_idx][r_resp_cnt[WSEL_W-1:0]] <= mem_rdata;
    if (!rst && r_state == S_DONE)
      r_tag[r_victim][r_fill_idx] <= r_fill_tag;
  end

  assign mem_rd   = r_mem_rd;
  assign mem_addr = r_mem_addr;
  assign hit_cnt  = r_hit_cnt;
  assign miss_cnt = r_miss_cnt;

endmodule
